// File: rtl/sha1_pkg.sv
// sha1_pkg: SHA-1 types and constants shared by the block sequencer, its interface and the core.
package sha1_pkg;
    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 160;
    typedef logic [4:0][31:0] hash_t;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_OUT} state_t;
    localparam hash_t IV = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};
    localparam logic [3:0][31:0] K = {32'hCA62C1D6, 32'h8F1BBCDC, 32'h6ED9EBA1, 32'h5A827999};
    // Digest bus carries H0 in the top word; hash_t carries H0 at index 0.
    function automatic hash_t to_hash(logic [DIGEST_W-1:0] d);
        hash_t h;
        for (int i = 0; i < 5; i++) h[i] = d[DIGEST_W-1-32*i -: 32];
        return h;
    endfunction
endpackage

// File: rtl/sha1_block_sequencer_if.sv
// sha1_block_sequencer_if: block stream, digest stream, status and core-side signals of the sequencer.
interface sha1_block_sequencer_if #(parameter int BLK_CNT_W = 16);
    import sha1_pkg::*;
    logic                 blk_valid, blk_ready, blk_last, abort;
    logic [BLOCK_W-1:0]   blk_data, core_message;
    logic                 dig_valid, dig_ready;
    logic [DIGEST_W-1:0]  dig_data, core_q_data;
    logic [BLK_CNT_W-1:0] blk_count;
    logic                 busy, core_start, core_done, timeout_err;
    hash_t                core_hash_i;
    modport slave (
        input  blk_valid, blk_data, blk_last, abort, dig_ready, core_done, core_q_data,
        output blk_ready, dig_valid, dig_data, blk_count, busy, core_start, core_message, core_hash_i, timeout_err
    );
    modport master (
        output blk_valid, blk_data, blk_last, abort, dig_ready, core_done, core_q_data,
        input  blk_ready, dig_valid, dig_data, blk_count, busy, core_start, core_message, core_hash_i, timeout_err
    );
endinterface

// File: rtl/sha1_block_sequencer.sv
// sha1_block_sequencer: chains padded 512-bit blocks through a single-block SHA-1 core.
// Optional core watchdog enabled by defining SHA1_SEQ_TIMEOUT_EN.
module sha1_block_sequencer
    import sha1_pkg::*;
#(
    parameter int BLK_CNT_W    = 16,
    parameter int CORE_TIMEOUT = 1023
) (
    input logic clk,
    input logic reset_n,
    sha1_block_sequencer_if.slave bus
);
    state_t               r_state, w_next;
    logic [1:0]           r_rst_sync;
    logic                 w_rst_n, w_hs, w_done, w_tout, r_last;
    logic [BLOCK_W-1:0]   r_msg;
    logic [DIGEST_W-1:0]  r_dig;
    logic [BLK_CNT_W-1:0] r_cnt;
    hash_t                r_chain;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_rst_sync <= 2'b00;
        else r_rst_sync <= {r_rst_sync[0], 1'b1};
    assign w_rst_n = r_rst_sync[1];

`ifdef SHA1_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(CORE_TIMEOUT + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_terr;
    assign w_tout = r_state == S_WAIT && !bus.core_done && r_tcnt == TW'(CORE_TIMEOUT - 1);
    always_ff @(posedge clk or negedge w_rst_n)
        if (!w_rst_n) begin
            r_tcnt <= '0;
            r_terr <= 1'b0;
        end else begin
            r_tcnt <= r_state == S_WAIT ? r_tcnt + 1'b1 : '0;
            r_terr <= !bus.abort && (r_terr || w_tout);
        end
    assign bus.timeout_err = r_terr;
`else
    assign w_tout = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.blk_ready    = w_rst_n && !bus.abort && (r_state == S_IDLE || r_state == S_LOAD);
    assign bus.dig_valid    = r_state == S_OUT && !bus.abort;
    assign bus.busy         = r_state != S_IDLE;
    assign bus.core_start   = r_state == S_START;
    assign bus.core_message = r_msg;
    assign bus.core_hash_i  = r_chain;
    assign bus.dig_data     = r_dig;
    assign bus.blk_count    = r_cnt;
    assign w_hs             = bus.blk_valid && bus.blk_ready;
    assign w_done           = r_state == S_WAIT && bus.core_done && !bus.abort;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_LOAD: w_next = w_hs ? S_START : r_state;
            S_START:        w_next = S_WAIT;
            S_WAIT:         w_next = bus.core_done ? (r_last ? S_OUT : S_LOAD) : (w_tout ? S_IDLE : S_WAIT);
            S_OUT:          w_next = bus.dig_ready ? S_IDLE : S_OUT;
            default:        w_next = S_IDLE;
        endcase
        if (bus.abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge w_rst_n)
        if (!w_rst_n) begin
            r_state <= S_IDLE;
            r_msg   <= '0;
            r_last  <= 1'b0;
            r_chain <= IV;
            r_dig   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (bus.abort || w_tout) r_chain <= IV;
            else if (w_hs) begin
                r_msg   <= bus.blk_data;
                r_last  <= bus.blk_last;
                r_chain <= r_state == S_IDLE ? IV : r_chain;
                r_cnt   <= r_state == S_IDLE ? BLK_CNT_W'(1) : r_cnt + BLK_CNT_W'(!(&r_cnt));
            end else if (w_done) begin
                r_chain <= to_hash(bus.core_q_data);
                r_dig   <= r_last ? bus.core_q_data : r_dig;
            end
        end
endmodule

// File: tb/tb_sha1_block_sequencer.sv
// tb_sha1_block_sequencer: scoreboard bench for the sequencer driven by a behavioural SHA-1 core model.
`timescale 1ns/1ps
module tb_sha1_block_sequencer;
    import sha1_pkg::*;
`ifdef SHA1_SEQ_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1023;
`endif
    localparam int CORE_LAT = 12;
    localparam logic [511:0] ABC = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
                                    32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
                                    32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B2  = {448'h0, 64'h1C0};
    localparam logic [159:0] D_ABC   = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
    localparam logic [159:0] D_2B    = 160'h84983E44_1C3BD26E_BAAE4AA1_F95129E5_E54670F1;
    localparam logic [159:0] IV_FLAT = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    typedef struct {
        logic [159:0] d;
        logic [15:0]  c;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    bit           suppress = 1'b0;
    int           checks = 0;
    int           errors = 0;
    int           starts = 0;
    exp_t         exp_q[$];
    hash_t        hash_log[$];
    logic [159:0] q_log[$];

    always #5 clk = ~clk;

    sha1_block_sequencer_if #(.BLK_CNT_W(16)) bus ();
    sha1_block_sequencer #(.BLK_CNT_W(16), .CORE_TIMEOUT(TO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    task automatic chk(string n, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", n, act, exp);
        end
    endtask

    function automatic logic [159:0] flat(hash_t h);
        return {h[0], h[1], h[2], h[3], h[4]};
    endfunction

    function automatic logic [159:0] compress(hash_t h, logic [511:0] m);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, t;
        a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
        for (int i = 0; i < 80; i++) begin
            if (i < 16) w[i] = m[511-32*i -: 32];
            else begin
                t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
                w[i] = {t[30:0], t[31]};
            end
            f = i < 20 ? (b & c) | (~b & d) : (i < 40 || i >= 60) ? b ^ c ^ d : (b & c) | (b & d) | (c & d);
            t = {a[26:0], a[31:27]} + f + e + K[i/20] + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {h[0] + a, h[1] + b, h[2] + c, h[3] + d, h[4] + e};
    endfunction

    // Core model: fixed latency, not resettable, result optionally withheld.
    initial begin
        hash_t        h;
        logic [511:0] m;
        logic [159:0] r;
        bus.core_done = 1'b0;
        bus.core_q_data = '0;
        forever begin
            @(negedge clk);
            if (bus.core_start) begin
                starts++;
                h = bus.core_hash_i;
                m = bus.core_message;
                r = compress(h, m);
                hash_log.push_back(h);
                q_log.push_back(r);
                repeat (CORE_LAT) @(negedge clk);
                if (!suppress) begin
                    bus.core_done = 1'b1;
                    bus.core_q_data = r;
                    @(negedge clk);
                    bus.core_done = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && bus.dig_valid && bus.dig_ready) begin
            if (exp_q.size() == 0) chk("digest_expected", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                chk("dig_data", bus.dig_data, e.d);
                chk("blk_count", bus.blk_count, e.c);
            end
        end
    end

    task automatic send(logic [511:0] data, logic last);
        int k = 0;
        @(posedge clk); #1;
        bus.blk_valid = 1'b1;
        bus.blk_data = data;
        bus.blk_last = last;
        do begin @(negedge clk); k++; end while (!bus.blk_ready && k < 200);
        chk("blk_accept", bus.blk_ready, 1);
        @(posedge clk); #1;
        bus.blk_valid = 1'b0;
    endtask

    task automatic wait_start();
        int k = 0;
        do begin @(negedge clk); k++; end while (!bus.core_start && k < 50);
        chk("core_start_seen", bus.core_start, 1);
    endtask

    task automatic drain(string n);
        int k = 0;
        while (exp_q.size() != 0 && k < 500) begin @(negedge clk); k++; end
        chk(n, exp_q.size(), 0);
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
    endtask

    initial begin
        int n0, ok, k;
        bus.blk_valid = 1'b0;
        bus.blk_data = '0;
        bus.blk_last = 1'b0;
        bus.abort = 1'b0;
        bus.dig_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dig_valid", bus.dig_valid, 0);
        chk("rst_blk_ready", bus.blk_ready, 0);
        chk("rst_core_start", bus.core_start, 0);
        chk("rst_blk_count", bus.blk_count, 0);
        chk("rst_hash_iv", flat(bus.core_hash_i), IV_FLAT);
        chk("rst_dig_data", bus.dig_data, 0);
        chk("rst_timeout", bus.timeout_err, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        n0 = starts;
        exp_q.push_back('{D_ABC, 16'd1});
        send(ABC, 1'b1);
        drain("abc_drain");
        chk("abc_starts", starts - n0, 1);
        @(negedge clk);
        chk("abc_idle", bus.busy, 0);

        hash_log.delete();
        q_log.delete();
        exp_q.push_back('{D_2B, 16'd2});
        send(B1, 1'b0);
        send(B2, 1'b1);
        drain("two_drain");
        chk("two_starts", hash_log.size(), 2);
        chk("two_hash0_iv", flat(hash_log[0]), IV_FLAT);
        chk("two_chain", flat(hash_log[1]), q_log[0]);

        bus.dig_ready = 1'b0;
        exp_q.push_back('{D_ABC, 16'd1});
        send(ABC, 1'b1);
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.dig_valid && k < 100);
        chk("bp_valid", bus.dig_valid, 1);
        ok = 0;
        repeat (20) begin
            @(negedge clk);
            ok += int'(bus.dig_valid && bus.dig_data == D_ABC && !bus.blk_ready && bus.busy);
        end
        chk("bp_stable", ok, 20);
        @(posedge clk); #1 bus.dig_ready = 1'b1;
        @(negedge clk);
        chk("bp_still_out", bus.busy, 1);
        @(negedge clk);
        chk("bp_idle", bus.busy, 0);
        chk("bp_valid_drop", bus.dig_valid, 0);
        chk("bp_drained", exp_q.size(), 0);

        send(B1, 1'b0);
        wait_start();
        repeat (3) @(negedge clk);
        pulse_abort();
        chk("abort_idle", bus.busy, 0);
        chk("abort_iv", flat(bus.core_hash_i), IV_FLAT);
        chk("abort_cnt", bus.blk_count, 1);
        repeat (30) @(negedge clk);
        chk("stray_busy", bus.busy, 0);
        chk("stray_cnt", bus.blk_count, 1);
        chk("stray_iv", flat(bus.core_hash_i), IV_FLAT);
        exp_q.push_back('{D_ABC, 16'd1});
        send(ABC, 1'b1);
        drain("abort_abc_drain");

        send(ABC, 1'b1);
        wait_start();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_dig_valid", bus.dig_valid, 0);
        chk("arst_core_start", bus.core_start, 0);
        chk("arst_blk_ready", bus.blk_ready, 0);
        chk("arst_blk_count", bus.blk_count, 0);
        chk("arst_hash_iv", flat(bus.core_hash_i), IV_FLAT);
        chk("arst_message", bus.core_message, 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("arst_stray_busy", bus.busy, 0);
        chk("arst_ready_back", bus.blk_ready, 1);

`ifdef SHA1_SEQ_TIMEOUT_EN
        suppress = 1'b1;
        send(ABC, 1'b1);
        wait_start();
        repeat (16) @(negedge clk);
        chk("to_wait16_busy", bus.busy, 1);
        chk("to_err_pre", bus.timeout_err, 0);
        @(negedge clk);
        chk("to_idle", bus.busy, 0);
        chk("to_err", bus.timeout_err, 1);
        chk("to_iv", flat(bus.core_hash_i), IV_FLAT);
        repeat (20) @(negedge clk);
        chk("to_err_sticky", bus.timeout_err, 1);
        suppress = 1'b0;
        pulse_abort();
        chk("to_err_cleared", bus.timeout_err, 0);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sha1_block_sequencer.md
Name: sha1_block_sequencer

Overview:
Sequences the existing single-block SHA-1 compression core (sha1_state_machine) across multi-block messages. It accepts padded 512-bit blocks over a valid/ready stream and loads each into the core. It feeds the core the standard IV for the first block and the previous block's result for every later block. It returns the final 160-bit digest over a valid/ready output. It sits between the software-facing block FIFO/bus interface and the SHA-1 core and owns the core's start, message and hash_value_i inputs.

Parameters:
- BLK_CNT_W, 16, width of the per-message block counter (saturates at all-ones).
- CORE_TIMEOUT, 1023, maximum cycles from core_start to core_done before a timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- blk_valid  in  1  input block available.
- blk_ready  out  1  sequencer accepts a block this cycle.
- blk_data  in  512  padded message block, same word ordering the core expects.
- blk_last  in  1  block is the final block of the message.
- abort  in  1  synchronous abort of the current message.
- dig_valid  out  1  digest available.
- dig_ready  in  1  consumer accepts the digest.
- dig_data  out  160  final digest; [159:128]=H0 … [31:0]=H4.
- blk_count  out  BLK_CNT_W  number of blocks processed in the current or last message.
- busy  out  1  high in any state except IDLE.
- core_start  out  1  one-cycle start pulse to the core.
- core_message  out  512  registered block to the core.
- core_hash_i  out  5x32  chaining value to the core; index 0 = H0.
- core_done  in  1  core result valid (one-cycle pulse).
- core_q_data  in  160  core result. This is the already-added chaining value H+abcde, [159:128]=H0.
- timeout_err  out  1  sticky timeout flag (tied 0 without the feature).

Behaviour:
- Reset (async assert, sync deassert inside the design):
  - state=IDLE.
  - All outputs 0, except core_hash_i, which resets to IV {67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0}.
  - blk_count=0.
- States: IDLE, LOAD, START, WAIT, OUT.
- IDLE:
  - blk_ready=1.
  - On a blk_valid&&blk_ready handshake: latch blk_data into core_message and latch blk_last. Set the chain register to the IV, set blk_count=1, go to START.
- LOAD (between blocks of a message):
  - blk_ready=1.
  - On a handshake: latch the block and last flag, increment blk_count (saturating), go to START.
  - The chain register holds the previous core_q_data.
- START:
  - core_start=1 for exactly one cycle, then go to WAIT.
  - core_message and core_hash_i stay stable from START until core_done.
- WAIT:
  - On core_done: chain register <= core_q_data.
  - If last: dig_data <= core_q_data and go to OUT. Otherwise go to LOAD.
  - A core_done arriving in any other state is ignored.
- OUT:
  - dig_valid=1, dig_data held stable.
  - On dig_ready, return to IDLE (dig_valid drops the next cycle).
  - blk_count holds its final value until the next message's first handshake.
- blk_ready is 0 in START, WAIT and OUT. There is no block buffering.
- Latency from the final core_done to dig_valid: 1 cycle. Latency from a block handshake to core_start: 1 cycle.
- abort:
  - Takes effect in any state: next state is IDLE, dig_valid=0, chain register reset to IV, blk_count kept.
  - If a core_done arrives in the same cycle as abort, abort wins.
  - The core is not reset; its next core_done is ignored because the sequencer is in IDLE.
- abort and a block handshake in the same cycle: abort wins and the block is dropped (blk_ready is forced 0 while abort=1).
- A message with zero blocks is impossible; every message ends with blk_last=1.
- busy = (state != IDLE).

Optional Feature:
- SHA1_SEQ_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT.
  - If it reaches CORE_TIMEOUT without core_done: timeout_err<=1 (sticky until reset or abort), state goes to IDLE, chain register resets to IV, dig_valid stays 0.
- Not defined: no counter; timeout_err is tied to 0 and WAIT waits indefinitely.

Decomposition:
- Package sha1_pkg holds:
  - the state enum type;
  - the IV constant array;
  - the K constant array (already passed to the core);
  - typedef hash_t (array of 5 x 32-bit words);
  - the BLOCK_W=512 and DIGEST_W=160 constants.
- The single RTL module instantiates no sub-module; the core is instantiated beside it at the top level.
- The bench uses a small wrapper that ties sha1_block_sequencer to sha1_state_machine.

Test Plan:
- Single block "abc" (blk_last=1) -> dig_data=A9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D, blk_count=1, exactly one core_start.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> dig_data=84983E44_1C3BD26E_BAAE4AA1_F95129E5_E54670F1, blk_count=2, and the second core_hash_i equals the first core_q_data.
- Digest backpressure: dig_ready=0 for 20 cycles -> dig_valid and dig_data stay stable, blk_ready=0 throughout, IDLE is entered one cycle after dig_ready=1.
- abort asserted in WAIT of block 1 of 2 -> IDLE next cycle, the stray core_done is ignored, then "abc" gives the correct digest.
- reset_n pulsed low mid-WAIT -> all outputs return to reset values immediately (asynchronously), core_hash_i=IV.
- With SHA1_SEQ_TIMEOUT_EN and CORE_TIMEOUT=16, core_done suppressed -> timeout_err=1 after 16 WAIT cycles, state IDLE, dig_valid never asserted.
